// File: rtl/level_check_monitor_if.sv
// Handshake/observation bundle between a level checker and whoever drives it.
// The slave side is the monitor; the master side drives start/abort and the level under check.
interface level_check_monitor_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic             expect_val;
  logic             sig_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] first_err_idx;

  modport master (
    output start, abort, expect_val, sig_in,
    input  busy, done, pass, fail, err_count, first_err_idx
  );

  modport slave (
    input  start, abort, expect_val, sig_in,
    output busy, done, pass, fail, err_count, first_err_idx
  );
endinterface

// File: rtl/level_check_monitor.sv
// Clocked level checker: samples sig_in for WINDOW cycles against a captured
// expected level, counts mismatches and reports a held PASS/FAIL verdict.
module level_check_monitor #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  level_check_monitor_if.slave mon
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] sample_cnt, err_cnt, err_next, first_idx;
  logic             exp_q, pass_q, fail_q;
  logic             accept, sample, last, mismatch;

  assign last     = (sample_cnt == LAST_IDX);
  assign mismatch = sample && (mon.sig_in != exp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // abort only matters in RUN; start only matters in IDLE/DONE
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    sample  = 1'b0;
    case (state_q)
      IDLE: if (mon.start) begin
        state_d = RUN;
        accept  = 1'b1;
      end
      RUN: if (mon.abort) begin
        state_d = IDLE;
      end else begin
        sample = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: if (mon.start) begin
        state_d = RUN;
        accept  = 1'b1;
      end else begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_next = err_cnt;
    if (mismatch && (err_cnt != ALL_ONES)) err_next = err_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q      <= 1'b0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      first_idx  <= ALL_ONES;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else if (accept) begin
      exp_q      <= mon.expect_val;
      sample_cnt <= '0;
      err_cnt    <= '0;
      first_idx  <= ALL_ONES;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else if (sample) begin
      sample_cnt <= sample_cnt + 1'b1;
      err_cnt    <= err_next;
      // a zero count means no mismatch has been seen yet in this window
      if (mismatch && (err_cnt == '0)) first_idx <= sample_cnt;
      if (last) begin
        pass_q <= (err_next == '0);
        fail_q <= (err_next != '0);
      end
    end
  end

  assign mon.busy          = (state_q == RUN);
  assign mon.done          = (state_q == DONE);
  assign mon.pass          = pass_q;
  assign mon.fail          = fail_q;
  assign mon.err_count     = err_cnt;
  assign mon.first_err_idx = first_idx;

endmodule

// File: doc/level_check_monitor.md
Name: level_check_monitor

Overview:
- Sequential checker that sits directly downstream of a constant-driving or output-only source stage and consumes that source's output level.
- On start, it samples one input bit for a fixed window of clock cycles and compares each sample against an expected level.
- It counts mismatches and issues a one-cycle done pulse with a held PASS/FAIL verdict.
- It replaces ad-hoc single-shot initial-block checks with a clocked, repeatable check.

Parameters:
- WINDOW, 16: number of samples per check; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of sample and error counters.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new check; honoured only in IDLE or DONE.
- abort  input  1  cancel a check in progress; returns to IDLE with no verdict.
- expect_val  input  1  expected level; captured on the accepted start.
- sig_in  input  1  level under check, from the upstream stage's output.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a window completes.
- pass  output  1  held high after a completed window with zero mismatches.
- fail  output  1  held high after a completed window with one or more mismatches.
- err_count  output  CNT_W  mismatches in the current or last window; saturating.
- first_err_idx  output  CNT_W  sample index (0-based) of the first mismatch; all-ones if none.

Behaviour:
- Reset (rst_n low, asynchronous) values:
  - state=IDLE; busy=0, done=0, pass=0, fail=0.
  - err_count=0; first_err_idx=all-ones; internal sample counter=0; captured expect=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k moves to RUN.
  - That edge captures expect_val, clears err_count and the sample counter, sets first_err_idx=all-ones, and clears pass and fail.
- RUN:
  - Samples sig_in at edges k+1 .. k+WINDOW; sample index i = 0..WINDOW-1.
  - Mismatch when sig_in != captured expect. err_count increments, saturating at 2^CNT_W-1.
  - On the first mismatch, first_err_idx=i.
  - At the edge taking sample WINDOW-1, go to DONE. That sample's mismatch is included in the verdict.
- DONE:
  - Lasts exactly one cycle; done=1 in that cycle.
  - pass = (final err_count==0) and fail = !pass, both set on entry.
  - Next edge: RUN if start=1 (same clear and capture as from IDLE), else IDLE.
- Latency: start accepted at edge k; done is high in the cycle after edge k+WINDOW.
- busy is high for exactly WINDOW cycles per check.
- pass, fail, err_count and first_err_idx hold after DONE until the next accepted start or reset.
- start while in RUN is ignored; it neither restarts nor extends the window.
- abort in RUN: next edge goes to IDLE, no done pulse.
  - pass and fail stay 0.
  - err_count and first_err_idx keep their partial values.
- abort in IDLE or DONE: no effect.
- abort and start in the same cycle: abort wins in RUN; start wins in IDLE or DONE.
- expect_val changes during RUN have no effect; only the captured value is used.
- Reset asserted mid-RUN: immediate return to reset values, no done pulse.
- pass and fail are never both 1; done is never high outside DONE.
- sig_in is treated as a synchronous 0/1 level. Upstream drives it from the same clock domain or a constant, so no synchroniser is required.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, no start -> busy=done=pass=fail=0, err_count=0, first_err_idx=8'hFF.
- Constant-high source: sig_in=1, expect_val=1, start one cycle (WINDOW=16) -> busy high 16 cycles; done pulse in cycle 17 after start; pass=1, fail=0, err_count=0, first_err_idx=8'hFF.
- Injected glitches: expect_val=1; sig_in=0 on samples 3 and 9 only -> done after 16 samples, fail=1, err_count=2, first_err_idx=3.
- Last-sample boundary: sig_in=0 only on sample 15 -> fail=1, err_count=1, first_err_idx=15.
- Control during RUN:
  - start pulsed at sample 5 -> window length unchanged at 16.
  - abort at sample 7 -> IDLE next cycle, no done, pass=fail=0.
  - rst_n low at sample 4 -> all outputs at reset values at once.
- Back-to-back and saturation:
  - start held high through DONE -> second RUN begins the cycle after done, with verdict cleared.
  - CNT_W=4, WINDOW=15, sig_in always != expect -> err_count=15, fail=1.
